// File: rtl/serpar_pkg.sv
// serpar_pkg: constants and state type shared by the serial_paralelo
// deserializer, the paralelo_serial serializer and their testbenches.
package serpar_pkg;

    // Idle/comma byte used for byte alignment.
    localparam logic [7:0] BC = 8'hBC;

    // Consecutive aligned commas needed before the link is declared active.
    localparam int BC_LOCK_DEF = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [7:0] b);
        return (b == BC);
    endfunction

endpackage

// File: rtl/serial_paralelo.sv
// serial_paralelo: MSB-first serial-to-parallel deserializer on clk_32f.
// Locks byte alignment on BC_LOCK consecutive aligned 0xBC commas, then
// delivers every non-comma byte on data_out with a one-cycle valid_out strobe.
// Optional build macro SERPAR_BYTE_CNT_EN adds the byte_cnt[15:0] output,
// a wrapping count of delivered bytes.
//
// state  | meaning
// HUNT   | sliding search for a comma at any bit offset
// ALIGN  | byte phase fixed, counting consecutive aligned commas
// ACTIVE | locked; non-comma bytes delivered, left only by reset
module serial_paralelo
    import serpar_pkg::*;
#(
    parameter int BC_LOCK = BC_LOCK_DEF
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        active
`ifdef SERPAR_BYTE_CNT_EN
    ,
    output logic [15:0] byte_cnt
`endif
);

    localparam int BCW = (BC_LOCK < 2) ? 1 : $clog2(BC_LOCK + 1);
    localparam logic [BCW-1:0] LOCK_V = BCW'(BC_LOCK);

    state_t         state_q, state_d;
    // Only the last seven bits are kept: together with data_in they form
    // the candidate byte, and the oldest bit is never looked at again.
    logic [6:0]     sr_q, sr_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] bc_cnt_q, bc_cnt_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           active_q, active_d;
`ifdef SERPAR_BYTE_CNT_EN
    logic [15:0]    byte_cnt_q, byte_cnt_d;
`endif

    logic [7:0]     cand;
    logic           comma;
    logic           at_last;
    logic [BCW-1:0] bc_inc;

    assign cand    = {sr_q, data_in};
    assign comma   = is_comma(cand);
    assign at_last = (bit_cnt_q == 3'd7);
    assign bc_inc  = bc_cnt_q + BCW'(1);

    // State and datapath registers; reset discards any partial byte and lock.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            bc_cnt_q   <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
`ifdef SERPAR_BYTE_CNT_EN
            byte_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            bc_cnt_q   <= bc_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
`ifdef SERPAR_BYTE_CNT_EN
            byte_cnt_q <= byte_cnt_d;
`endif
        end
    end

    // Next-state and output decode: comma search, lock counting, byte delivery.
    always_comb begin
        state_d    = state_q;
        sr_d       = cand[6:0];
        bit_cnt_d  = bit_cnt_q;
        bc_cnt_d   = bc_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        active_d   = active_q;
`ifdef SERPAR_BYTE_CNT_EN
        byte_cnt_d = byte_cnt_q;
`endif

        case (state_q)
            HUNT: begin
                if (comma) begin
                    bc_cnt_d  = BCW'(1);
                    bit_cnt_d = 3'd0;
                    if (BC_LOCK <= 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d  = ALIGN;
                    end
                end
            end

            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (at_last) begin
                    if (comma) begin
                        bc_cnt_d = bc_inc;
                        if (bc_inc == LOCK_V) begin
                            state_d  = ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d   = HUNT;
                        bc_cnt_d  = '0;
                        bit_cnt_d = 3'd0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                // Commas are idle fill: no strobe and data_out keeps the last byte.
                if (at_last && !comma) begin
                    data_d  = cand;
                    valid_d = 1'b1;
`ifdef SERPAR_BYTE_CNT_EN
                    byte_cnt_d = byte_cnt_q + 16'd1;
`endif
                end
            end

            default: begin
                state_d   = HUNT;
                bc_cnt_d  = '0;
                bit_cnt_d = 3'd0;
                active_d  = 1'b0;
            end
        endcase
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;
`ifdef SERPAR_BYTE_CNT_EN
    assign byte_cnt  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: self-checking bench for serial_paralelo.
// A bit-stream reference model (edge index arithmetic relative to the
// alignment anchor) is compared against the outputs after every clock edge;
// a table of byte records and a few hand-written sequences add fixed checks.
module tb_serial_paralelo;
    import serpar_pkg::*;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        data_in;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active;
`ifdef SERPAR_BYTE_CNT_EN
    logic [15:0] byte_cnt;
`endif

    serial_paralelo dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef SERPAR_BYTE_CNT_EN
        ,
        .byte_cnt  (byte_cnt)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model state.
    int          m_edge;
    int          m_anchor;
    int          m_commas;
    logic [7:0]  m_win;
    logic        m_in_hunt;
    logic        m_locked;
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_bytes;

    typedef struct {
        logic [7:0] din;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_active;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_edge    = 0;
        m_anchor  = 0;
        m_commas  = 0;
        m_win     = 8'h00;
        m_in_hunt = 1'b1;
        m_locked  = 1'b0;
        m_valid   = 1'b0;
        m_data    = 8'h00;
        m_bytes   = 0;
    endtask

    // One received bit: the last eight bits form a window; once a comma
    // has been seen, every 8th edge after it is a byte boundary.
    task automatic model_step(input logic b);
        logic boundary;
        m_edge++;
        m_win    = 8'((m_win << 1) | {7'd0, b});
        boundary = !m_in_hunt && (((m_edge - m_anchor) % 8) == 0);
        m_valid  = 1'b0;
        if (m_in_hunt) begin
            if (m_win == BC) begin
                m_in_hunt = 1'b0;
                m_anchor  = m_edge;
                m_commas  = 1;
                if (m_commas >= BC_LOCK_DEF) m_locked = 1'b1;
            end
        end else if (boundary) begin
            if (!m_locked) begin
                if (m_win == BC) begin
                    m_commas++;
                    if (m_commas >= BC_LOCK_DEF) m_locked = 1'b1;
                end else begin
                    m_in_hunt = 1'b1;
                    m_commas  = 0;
                end
            end else if (m_win != BC) begin
                m_valid = 1'b1;
                m_data  = m_win;
                m_bytes = (m_bytes + 1) % 65536;
            end
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        if (valid_out === 1'b1) pulses++;
        chk("model_data_out", data_out, m_data);
        chk("model_valid_out", valid_out, m_valid);
        chk("model_active", active, m_locked);
`ifdef SERPAR_BYTE_CNT_EN
        chk("model_byte_cnt", byte_cnt, m_bytes);
`endif
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Called #1 after an edge; holds reset for the given number of edges.
    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_now_data", data_out, 8'h00);
        chk("rst_now_valid", valid_out, 1'b0);
        chk("rst_now_active", active, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            data_in = ~data_in;
            @(posedge clk_32f);
            #1;
            chk("rst_hold_data", data_out, 8'h00);
            chk("rst_hold_valid", valid_out, 1'b0);
            chk("rst_hold_active", active, 1'b0);
`ifdef SERPAR_BYTE_CNT_EN
            chk("rst_hold_byte_cnt", byte_cnt, 16'h0000);
`endif
        end
        reset = 1'b0;
        pulses = 0;
    endtask

    initial begin
        tbl[0]  = '{8'hBC, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{8'hBC, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{8'hBC, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{8'hBC, 1'b0, 8'h00, 1'b1};
        tbl[4]  = '{8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[5]  = '{8'hEE, 1'b1, 8'hEE, 1'b1};
        tbl[6]  = '{8'hBC, 1'b0, 8'hEE, 1'b1};
        tbl[7]  = '{8'h7F, 1'b1, 8'h7F, 1'b1};
        tbl[8]  = '{8'hBC, 1'b0, 8'h7F, 1'b1};
        tbl[9]  = '{8'hBC, 1'b0, 8'h7F, 1'b1};
        tbl[10] = '{8'h03, 1'b1, 8'h03, 1'b1};

        reset   = 1'b1;
        data_in = 1'b0;
        model_reset();
        @(posedge clk_32f);
        #1;

        // Reset held 5 cycles with data_in toggling.
        apply_reset(5);
        chk("state_hunt_after_reset", dut.state_q, HUNT);

        // Aligned lock followed by data and idle bytes.
        for (int i = 0; i < 11; i++) begin
            send_byte(tbl[i].din);
            chk("tbl_valid", valid_out, tbl[i].exp_valid);
            chk("tbl_data", data_out, tbl[i].exp_data);
            chk("tbl_active", active, tbl[i].exp_active);
        end
        chk("tbl_pulses", pulses, 4);
`ifdef SERPAR_BYTE_CNT_EN
        chk("tbl_byte_cnt", byte_cnt, 16'd4);
`endif

        // Reset in the middle of a data byte while active.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("midbyte_rst_data", data_out, 8'h00);
        chk("midbyte_rst_valid", valid_out, 1'b0);
        chk("midbyte_rst_active", active, 1'b0);
        @(posedge clk_32f);
        #1;
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) send_byte(BC);
        send_byte(8'h12);
        chk("relock_3bc_active", active, 1'b0);
        chk("relock_3bc_pulses", pulses, 0);
        for (int i = 0; i < 4; i++) send_byte(BC);
        chk("relock_4bc_active", active, 1'b1);
        send_byte(8'h34);
        chk("relock_pulses", pulses, 1);
        chk("relock_data", data_out, 8'h34);

        // Lock at bit offset 3 after junk bits 101.
        apply_reset(2);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_byte(BC);
        chk("off3_not_yet_active", active, 1'b0);
        send_byte(BC);
        chk("off3_active", active, 1'b1);
        send_byte(8'hEE);
        chk("off3_valid", valid_out, 1'b1);
        chk("off3_data", data_out, 8'hEE);
        send_byte(BC);
        send_byte(BC);
        chk("off3_pulses", pulses, 1);
        chk("off3_data_hold", data_out, 8'hEE);

        // Three commas then a non-comma: back to hunting, then relock.
        apply_reset(2);
        for (int i = 0; i < 3; i++) send_byte(BC);
        send_byte(8'h55);
        chk("bc3_55_active", active, 1'b0);
        chk("bc3_55_pulses", pulses, 0);
        for (int i = 0; i < 4; i++) send_byte(BC);
        chk("bc3_55_relock", active, 1'b1);

        // Randomised streams: noise, commas at random offset, mixed bytes.
        for (int r = 0; r < 6; r++) begin
            apply_reset(1);
            for (int n = 0; n < int'($urandom_range(0, 20)); n++)
                send_bit(1'($urandom));
            for (int i = 0; i < 4; i++) send_byte(BC);
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(0, 2) == 0) send_byte(BC);
                else send_byte(8'($urandom));
            end
        end
        apply_reset(1);
        for (int n = 0; n < 200; n++) send_bit(1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
